// File: rtl/timer_alarm_core_pkg.sv
// Shared definitions for the countdown alarm: FSM state encoding,
// overrun counter width and the alarm counter width helper.
package timer_alarm_core_pkg;

    // Alarm FSM states; the encoding matches the register-bank view.
    typedef enum logic [1:0] {
        ALARM_IDLE  = 2'd0,
        ALARM_COUNT = 2'd1,
        ALARM_DONE  = 2'd2
    } alarm_state_t;

    // Width of the optional overrun counter and its saturation value.
    localparam int ALARM_OVERRUN_W = 8;
    localparam logic [ALARM_OVERRUN_W-1:0] ALARM_OVERRUN_MAX = '1;

    // The alarm counter is twice the bus width so a full 64-bit tick
    // count can be programmed over two bus words.
    function automatic int alarm_cnt_w(input int data_w);
        return 2 * data_w;
    endfunction

endpackage

// File: rtl/timer_alarm_downcnt.sv
// Loadable, enable-gated down counter with an is-one flag.
// Load has priority over decrement; the counter never decrements
// below zero so it cannot wrap.
module timer_alarm_downcnt
    import timer_alarm_core_pkg::*;
#(
    parameter int CNT_W = alarm_cnt_w(32)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             is_one
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    // Counter register: load wins, otherwise decrement while enabled
    // and non-zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= CNT_ZERO;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != CNT_ZERO)) begin
            count <= count - CNT_ONE;
        end
    end

    // Expiry is detected one tick early, at a count of one.
    always_comb begin
        is_one = (count == CNT_ONE);
    end

endmodule

// File: rtl/timer_alarm_core.sv
// Countdown alarm core. Software loads a tick count; the block counts
// it down while enabled and, on expiry, emits a one-cycle pulse and
// sets a sticky interrupt flag. One-shot or periodic (auto-reload).
//
// Optional build macro TIMER_ALARM_OVERRUN_EN adds ALARM_OVERRUN, an
// 8-bit saturating count of expiries that happen while ALARM_IRQ is
// still pending.
//
// Strobe semantics: ALARM_LOAD and ALARM_CLEAR are single-cycle
// strobes sampled on the rising edge of clk; ALARM_ENABLE is a level.
// ALARM_PULSE is valid for exactly the cycle after the expiry edge.
module timer_alarm_core
    import timer_alarm_core_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ALARM_ENABLE,
    input  logic                        ALARM_PERIODIC,
    input  logic                        ALARM_LOAD,
    input  logic [2*DATA_W-1:0]         ALARM_LOAD_VALUE,
    input  logic                        ALARM_CLEAR,
    output logic [2*DATA_W-1:0]         ALARM_REMAIN,
    output logic                        ALARM_BUSY,
    output logic                        ALARM_PULSE,
`ifdef TIMER_ALARM_OVERRUN_EN
    output logic                        ALARM_IRQ,
    output logic [ALARM_OVERRUN_W-1:0]  ALARM_OVERRUN
`else
    output logic                        ALARM_IRQ
`endif
);

    localparam int CNT_W = alarm_cnt_w(DATA_W);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    // FSM state; kept as a named enum so checkers can bind to it.
    alarm_state_t state;
    alarm_state_t state_nxt;

    logic [CNT_W-1:0] reload_q;
    logic             periodic_q;
    logic             pulse_q;
    logic             irq_q;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_value;
    logic             cnt_dec;
    logic             cnt_is_one;
    logic [CNT_W-1:0] cnt_value;
    logic             counting;
    logic             expiry;

    // Counting happens only in COUNT with enable high; a load in the
    // same cycle pre-empts both the decrement and any expiry.
    always_comb begin
        counting       = (state == ALARM_COUNT) && ALARM_ENABLE && !ALARM_LOAD;
        expiry         = counting && cnt_is_one;
        cnt_dec        = counting;
        cnt_load       = ALARM_LOAD || (expiry && periodic_q);
        cnt_load_value = ALARM_LOAD ? ALARM_LOAD_VALUE : reload_q;
    end

    timer_alarm_downcnt #(
        .CNT_W (CNT_W)
    ) u_downcnt (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .dec        (cnt_dec),
        .count      (cnt_value),
        .is_one     (cnt_is_one)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ALARM_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: load re-arms (or disarms on zero) from any state;
    // a one-shot expiry parks in DONE; IDLE and DONE only leave via load.
    always_comb begin
        state_nxt = state;
        case (state)
            ALARM_IDLE:  state_nxt = ALARM_IDLE;
            ALARM_COUNT: begin
                if (expiry && !periodic_q) begin
                    state_nxt = ALARM_DONE;
                end
            end
            ALARM_DONE:  state_nxt = ALARM_DONE;
            default:     state_nxt = ALARM_IDLE;
        endcase
        if (ALARM_LOAD) begin
            state_nxt = (ALARM_LOAD_VALUE != CNT_ZERO) ? ALARM_COUNT : ALARM_IDLE;
        end
    end

    // FSM outputs: busy is a direct decode of the state register.
    always_comb begin
        ALARM_BUSY = 1'b0;
        if (state == ALARM_COUNT) begin
            ALARM_BUSY = 1'b1;
        end
    end

    // Reload value and mode are captured on every load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reload_q   <= CNT_ZERO;
            periodic_q <= 1'b0;
        end else if (ALARM_LOAD) begin
            reload_q   <= ALARM_LOAD_VALUE;
            periodic_q <= ALARM_PERIODIC;
        end
    end

    // Expiry pulse and sticky interrupt; a simultaneous expiry beats clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            pulse_q <= expiry;
            if (expiry) begin
                irq_q <= 1'b1;
            end else if (ALARM_CLEAR) begin
                irq_q <= 1'b0;
            end
        end
    end

`ifdef TIMER_ALARM_OVERRUN_EN
    logic [ALARM_OVERRUN_W-1:0] overrun_q;

    // Overrun count: expiries while the irq is still pending, saturating;
    // clear has priority over a simultaneous increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q <= '0;
        end else if (ALARM_CLEAR) begin
            overrun_q <= '0;
        end else if (expiry && irq_q && (overrun_q != ALARM_OVERRUN_MAX)) begin
            overrun_q <= overrun_q + ALARM_OVERRUN_W'(1);
        end
    end

    // Overrun output drive.
    always_comb begin
        ALARM_OVERRUN = overrun_q;
    end
`endif

    // Registered outputs.
    always_comb begin
        ALARM_REMAIN = cnt_value;
        ALARM_PULSE  = pulse_q;
        ALARM_IRQ    = irq_q;
    end

endmodule

// File: tb/tb_timer_alarm_core.sv
// Testbench for timer_alarm_core: directed scenarios plus random
// stimulus, checked cycle by cycle against a tick-counting reference
// model through an expected-value queue.
module tb_timer_alarm_core;

    localparam int DATA_W = 32;
    localparam int CW     = 2 * DATA_W;

    logic          clk = 1'b0;
    logic          rst;
    logic          alarm_enable;
    logic          alarm_periodic;
    logic          alarm_load;
    logic [CW-1:0] alarm_load_value;
    logic          alarm_clear;
    logic [CW-1:0] alarm_remain;
    logic          alarm_busy;
    logic          alarm_pulse;
    logic          alarm_irq;
    logic [7:0]    alarm_overrun_obs;

    // Clock.
    always #5 clk = ~clk;

    timer_alarm_core #(
        .DATA_W (DATA_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .ALARM_ENABLE     (alarm_enable),
        .ALARM_PERIODIC   (alarm_periodic),
        .ALARM_LOAD       (alarm_load),
        .ALARM_LOAD_VALUE (alarm_load_value),
        .ALARM_CLEAR      (alarm_clear),
        .ALARM_REMAIN     (alarm_remain),
        .ALARM_BUSY       (alarm_busy),
        .ALARM_PULSE      (alarm_pulse),
`ifdef TIMER_ALARM_OVERRUN_EN
        .ALARM_IRQ        (alarm_irq),
        .ALARM_OVERRUN    (alarm_overrun_obs)
`else
        .ALARM_IRQ        (alarm_irq)
`endif
    );

`ifndef TIMER_ALARM_OVERRUN_EN
    assign alarm_overrun_obs = 8'd0;
`endif

    typedef struct packed {
        logic [CW-1:0] remain;
        logic          busy;
        logic          pulse;
        logic          irq;
        logic [7:0]    over;
    } obs_t;
    localparam int OBS_W = $bits(obs_t);

    logic [OBS_W-1:0] exp_q[$];
    int pulse_q[$];
    int want_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int drv_idx  = 0;
    int mon_idx  = 0;

    // Reference model: ticks left, armed flag, reload value, mode,
    // sticky irq and overrun count.
    logic [CW-1:0] m_left;
    logic [CW-1:0] m_reload;
    bit            m_armed;
    bit            m_periodic;
    bit            m_irq;
    int            m_over;

    function automatic void model_reset();
        m_left     = '0;
        m_reload   = '0;
        m_armed    = 1'b0;
        m_periodic = 1'b0;
        m_irq      = 1'b0;
        m_over     = 0;
    endfunction

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; the model predicts the outputs after the edge.
    task automatic step(input bit ld, input logic [CW-1:0] val, input bit per,
                        input bit en, input bit clr);
        obs_t e;
        bit   pulse;
        bit   irq_old;
        @(negedge clk);
        alarm_load       = ld;
        alarm_load_value = val;
        alarm_periodic   = per;
        alarm_enable     = en;
        alarm_clear      = clr;
        pulse   = 1'b0;
        irq_old = m_irq;
        if (ld) begin
            m_reload   = val;
            m_periodic = per;
            m_left     = val;
            m_armed    = (val != '0);
        end else if (m_armed && en) begin
            m_left = m_left - 1;
            if (m_left == '0) begin
                pulse = 1'b1;
                if (m_periodic) m_left = m_reload;
                else m_armed = 1'b0;
            end
        end
        if (pulse) m_irq = 1'b1;
        else if (clr) m_irq = 1'b0;
        if (clr) m_over = 0;
        else if (pulse && irq_old && m_over < 255) m_over = m_over + 1;
        e.remain = m_left;
        e.busy   = m_armed;
        e.pulse  = pulse;
        e.irq    = m_irq;
`ifdef TIMER_ALARM_OVERRUN_EN
        e.over   = 8'(m_over);
`else
        e.over   = 8'd0;
`endif
        exp_q.push_back(e);
        drv_idx++;
    endtask

    task automatic run(input int n, input bit en);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, en, 1'b0);
    endtask

    // Let the monitor consume the last expectation, then park the inputs
    // so the DUT holds still until the next step.
    task automatic drain();
        @(posedge clk);
        #2;
        alarm_load   = 1'b0;
        alarm_clear  = 1'b0;
        alarm_enable = 1'b0;
    endtask

    task automatic check_pulses(input string name);
        check({name, " count"}, CW'(pulse_q.size()), CW'(want_q.size()));
        for (int i = 0; i < want_q.size(); i++) begin
            if (i < pulse_q.size()) check({name, " index"}, CW'(pulse_q[i]), CW'(want_q[i]));
        end
        pulse_q.delete();
        want_q.delete();
    endtask

    // Monitor: after every edge, compare the DUT against the next expectation.
    initial begin
        obs_t a;
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e        = exp_q.pop_front();
                a.remain = alarm_remain;
                a.busy   = alarm_busy;
                a.pulse  = alarm_pulse;
                a.irq    = alarm_irq;
                a.over   = alarm_overrun_obs;
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL cycle %0d outputs: got remain=%0h busy=%0b pulse=%0b irq=%0b ovr=%0d, expected remain=%0h busy=%0b pulse=%0b irq=%0b ovr=%0d",
                             mon_idx, a.remain, a.busy, a.pulse, a.irq, a.over,
                             e.remain, e.busy, e.pulse, e.irq, e.over);
                end
                if (a.pulse) pulse_q.push_back(mon_idx);
                mon_idx++;
            end
        end
    end

    // Main sequence.
    initial begin
        int k;
        rst              = 1'b1;
        alarm_enable     = 1'b0;
        alarm_periodic   = 1'b0;
        alarm_load       = 1'b0;
        alarm_load_value = '0;
        alarm_clear      = 1'b0;
        model_reset();
        #12;
        check("reset remain", alarm_remain, '0);
        check("reset busy", CW'(alarm_busy), '0);
        check("reset pulse", CW'(alarm_pulse), '0);
        check("reset irq", CW'(alarm_irq), '0);
        @(negedge clk);
        rst = 1'b0;

        // One-shot 1000.
        k = drv_idx;
        step(1'b1, CW'(1000), 1'b0, 1'b1, 1'b0);
        run(4000, 1'b1);
        drain();
        want_q.push_back(k + 1000);
        check_pulses("oneshot pulse");
        check("oneshot irq", CW'(alarm_irq), CW'(1));
        check("oneshot remain", alarm_remain, '0);
        check("oneshot busy", CW'(alarm_busy), '0);

        // Periodic 5 with a clear in between.
        k = drv_idx;
        step(1'b1, CW'(5), 1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 16; i++) step(1'b0, '0, 1'b0, 1'b1, (i == 7));
        drain();
        want_q.push_back(k + 5);
        want_q.push_back(k + 10);
        want_q.push_back(k + 15);
        check_pulses("periodic pulse");
        check("periodic busy", CW'(alarm_busy), CW'(1));

        // Enable gap of 20 cycles.
        k = drv_idx;
        step(1'b1, CW'(100), 1'b0, 1'b1, 1'b0);
        run(40, 1'b1);
        drain();
        check("gap remain start", alarm_remain, CW'(60));
        run(20, 1'b0);
        drain();
        check("gap remain end", alarm_remain, CW'(60));
        run(100, 1'b1);
        drain();
        want_q.push_back(k + 120);
        check_pulses("gap pulse");

        // Clear in the expiry cycle, then load in the next expiry cycle.
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        k = drv_idx;
        step(1'b1, CW'(10), 1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 9; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        drain();
        check("clear vs expiry irq", CW'(alarm_irq), CW'(1));
        for (int i = 11; i <= 19; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b1, CW'(50), 1'b1, 1'b1, 1'b0);
        run(60, 1'b1);
        drain();
        want_q.push_back(k + 10);
        want_q.push_back(k + 70);
        check_pulses("load vs expiry pulse");

        // Load 0 while counting disarms.
        step(1'b1, CW'(300), 1'b0, 1'b1, 1'b0);
        run(50, 1'b1);
        step(1'b1, '0, 1'b0, 1'b1, 1'b0);
        run(400, 1'b1);
        drain();
        check_pulses("disarm pulse");
        check("disarm busy", CW'(alarm_busy), '0);
        check("disarm remain", alarm_remain, '0);

        // Asynchronous reset mid-count.
        step(1'b1, CW'(1000), 1'b0, 1'b1, 1'b0);
        run(600, 1'b1);
        drain();
        check("pre-reset remain", alarm_remain, CW'(400));
        #1 rst = 1'b1;
        #1;
        check("async reset remain", alarm_remain, '0);
        check("async reset busy", CW'(alarm_busy), '0);
        check("async reset pulse", CW'(alarm_pulse), '0);
        check("async reset irq", CW'(alarm_irq), '0);
        check("async reset overrun", CW'(alarm_overrun_obs), '0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        pulse_q.delete();

`ifdef TIMER_ALARM_OVERRUN_EN
        // Overrun counting, clearing and saturation.
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b1, CW'(4), 1'b1, 1'b1, 1'b0);
        run(40, 1'b1);
        drain();
        check("overrun count", CW'(alarm_overrun_obs), CW'(9));
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        drain();
        check("overrun cleared", CW'(alarm_overrun_obs), '0);
        check("overrun irq cleared", CW'(alarm_irq), '0);
        step(1'b1, CW'(1), 1'b1, 1'b1, 1'b0);
        run(300, 1'b1);
        drain();
        check("overrun saturate", CW'(alarm_overrun_obs), CW'(255));
        pulse_q.delete();
`endif

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 99) < 4),
                 CW'($urandom_range(0, 24)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 99) < 85),
                 ($urandom_range(0, 99) < 6));
        end
        drain();
        pulse_q.delete();
        check("queue drained", CW'(exp_q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
